// File: rtl/vga_scan_gen.sv
// VGA scan generator: pixel/line counters, sync/DE decode and colour gating.
// Define SCAN_SYNC_DELAY_EN to add one extra tick stage on sync/DE/colour.
module vga_scan_gen #(
    parameter int H_VIS  = 1440,
    parameter int H_FP   = 80,
    parameter int H_SYNC = 152,
    parameter int H_BP   = 232,
    parameter int V_VIS  = 900,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [3:0]  draw_r,
    input  logic [3:0]  draw_g,
    input  logic [3:0]  draw_b,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] X_VIS  = 11'(H_VIS);
    localparam logic [10:0] X_SS   = 11'(H_VIS + H_FP);
    localparam logic [10:0] X_SE   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  Y_LAST = 10'(V_TOT - 1);
    localparam logic [9:0]  Y_VIS  = 10'(V_VIS);
    localparam logic [9:0]  Y_SS   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  Y_SE   = 10'(V_VIS + V_FP + V_SYNC);

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [11:0] rgb_q, rgb_d;
    logic        fs_q, fs_d;
    logic        vis, hs_act, vs_act;

`ifdef SCAN_SYNC_DELAY_EN
    logic        vis1_q, vis1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic [11:0] rgb1_q, rgb1_d;
`endif

    always_comb begin
        vis    = (x_q < X_VIS) && (y_q < Y_VIS);
        hs_act = (x_q >= X_SS) && (x_q < X_SE);
        vs_act = (y_q >= Y_SS) && (y_q < Y_SE);

        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        rgb_d   = rgb_q;
        fs_d    = 1'b0;
`ifdef SCAN_SYNC_DELAY_EN
        vis1_d  = vis1_q;
        hs1_d   = hs1_q;
        vs1_d   = vs1_q;
        rgb1_d  = rgb1_q;
`endif

        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d = 11'd0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
            fs_d = (x_q == X_LAST) && (y_q == Y_LAST);
`ifdef SCAN_SYNC_DELAY_EN
            vis1_d  = vis;
            hs1_d   = hs_act;
            vs1_d   = vs_act;
            rgb1_d  = {draw_r, draw_g, draw_b};
            hsync_d = ~hs1_q;
            vsync_d = vs1_q;
            de_d    = vis1_q;
            rgb_d   = vis1_q ? rgb1_q : 12'h000;
`else
            hsync_d = ~hs_act;
            vsync_d = vs_act;
            de_d    = vis;
            rgb_d   = vis ? {draw_r, draw_g, draw_b} : 12'h000;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= 11'd0;
            y_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            rgb_q   <= 12'h000;
            fs_q    <= 1'b0;
`ifdef SCAN_SYNC_DELAY_EN
            vis1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            rgb1_q  <= 12'h000;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
`ifdef SCAN_SYNC_DELAY_EN
            vis1_q  <= vis1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            rgb1_q  <= rgb1_d;
`endif
        end
    end

    assign curr_x      = x_q;
    assign curr_y      = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: full-size instance for line timing, scaled
// instance (32x18 total) for frame wrap, frame_start and mid-frame reset.
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pix_en;
    logic [3:0] dr, dg, db;

    logic [10:0] a_x, s_x;
    logic [9:0]  a_y, s_y;
    logic        a_hs, a_vs, a_de, a_fs;
    logic        s_hs, s_vs, s_de, s_fs;
    logic [3:0]  a_r, a_g, a_b, s_r, s_g, s_b;

`ifdef SCAN_SYNC_DELAY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    vga_scan_gen u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .draw_r(dr), .draw_g(dg), .draw_b(db),
        .curr_x(a_x), .curr_y(a_y),
        .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .frame_start(a_fs)
    );

    vga_scan_gen #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VIS(10), .V_FP(2), .V_SYNC(3), .V_BP(3)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .draw_r(dr), .draw_g(dg), .draw_b(db),
        .curr_x(s_x), .curr_y(s_y),
        .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .frame_start(s_fs)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hs_low, bad, s_fs_n, s_fs_first, s_vs_n, s_de_n;
    int hs_clk, fs_clk, fs_rise;
    logic fs_prev;

    initial begin
        rst = 1'b1; pix_en = 1'b0;
        dr = 4'hA; dg = 4'h5; db = 4'hF;
        step(); step();
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_hs", a_hs, 1);
        check("rst_vs", a_vs, 0);
        check("rst_de", a_de, 0);
        check("rst_rgb", {a_r, a_g, a_b}, 0);
        check("rst_fs", s_fs, 0);

        // First line of the full-size timing, plus three small frames.
        rst = 1'b0; pix_en = 1'b1;
        hs_low = 0; bad = 0; s_fs_n = 0; s_fs_first = -1;
        s_vs_n = 0; s_de_n = 0;
        for (int k = 1; k <= 1908; k++) begin
            step();
            if (!a_hs) hs_low++;
            if (!a_de && {a_r, a_g, a_b} != 12'h0) bad++;
            if (!s_de && {s_r, s_g, s_b} != 12'h0) bad++;
            if (s_fs) begin
                s_fs_n++;
                if (s_fs_first < 0) s_fs_first = k;
            end
            if (s_vs) s_vs_n++;
            if (s_de && k <= 576) s_de_n++;
            if (k == 4 + LAT) check("rgb_old", a_r, 4'hA);
            if (k == 5 + LAT) check("rgb_new_r", a_r, 4'h3);
            if (k == 5 + LAT) check("rgb_new_g", a_g, 4'hC);
            if (k == 1439 + LAT) check("de_last", a_de, 1);
            if (k == 1439 + LAT) check("rgb_last", a_b, 4'h7);
            if (k == 1440 + LAT) check("de_fall", a_de, 0);
            if (k == 1440 + LAT) check("rgb_blank", a_r, 0);
            if (k == 1519 + LAT) check("hs_pre", a_hs, 1);
            if (k == 1520 + LAT) check("hs_fall", a_hs, 0);
            if (k == 1671 + LAT) check("hs_end", a_hs, 0);
            if (k == 1672 + LAT) check("hs_rise", a_hs, 1);
            if (k == 1903) check("x_max", a_x, 1903);
            if (k == 1903) check("y_line0", a_y, 0);
            if (k == 1904) check("x_wrap", a_x, 0);
            if (k == 1904) check("y_inc", a_y, 1);
            if (k == 5) begin
                dr = 4'h3; dg = 4'hC; db = 4'h7;
            end
        end
        check("hs_width", hs_low, 152);
        check("rgb_gate", bad, 0);
        check("s_fs_first", s_fs_first, 576);
        check("s_fs_count", s_fs_n, 3);
        check("s_vs_ticks", s_vs_n, 288);
        check("s_de_ticks", s_de_n, 160);

        // Pixel enable toggling every clk.
        rst = 1'b1; step(); step();
        rst = 1'b0; pix_en = 1'b1;
        hs_clk = 0; fs_clk = 0; fs_rise = 0; fs_prev = 1'b0;
        for (int c = 1; c <= 3400; c++) begin
            step();
            if (!a_hs) hs_clk++;
            if (s_fs) fs_clk++;
            if (s_fs && !fs_prev) fs_rise++;
            fs_prev = s_fs;
            if (c == 11) check("tog_x_tick", a_x, 6);
            if (c == 12) check("tog_x_hold", a_x, 6);
            pix_en = ~pix_en;
        end
        check("tog_hs_clk", hs_clk, 304);
        check("tog_fs_clk", fs_clk, 2);
        check("tog_fs_rise", fs_rise, 2);
        check("tog_x_end", a_x, 1700);

        // Reset asserted mid-frame.
        pix_en = 1'b1; rst = 1'b1; step();
        rst = 1'b0;
        for (int k = 0; k < 2604; k++) step();
        check("mid_x", a_x, 700);
        check("mid_y", a_y, 1);
        rst = 1'b1; step(); step(); step();
        check("mr_x", a_x, 0);
        check("mr_y", a_y, 0);
        check("mr_hs", a_hs, 1);
        check("mr_de", a_de, 0);
        check("mr_rgb", {a_r, a_g, a_b}, 0);
        check("mr_s_x", s_x, 0);
        check("mr_s_y", s_y, 0);
        check("mr_fs", s_fs, 0);
        rst = 1'b0;
        s_fs_n = 0; s_fs_first = -1;
        for (int k = 1; k <= 576; k++) begin
            step();
            if (s_fs) begin
                s_fs_n++;
                if (s_fs_first < 0) s_fs_first = k;
            end
            if (k == 1) check("rel_x", a_x, 1);
            if (k == 1) check("rel_hs", a_hs, 1);
        end
        check("rel_fs_first", s_fs_first, 576);
        check("rel_fs_count", s_fs_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameters H_VIS=1440, H_FP=80, H_SYNC=152, H_BP=232, V_VIS=900, V_FP=3, V_SYNC=6, V_BP=25 (pixels/lines).
REQ-002 SHALL have ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel-clock enable; the block advances only on clk edges with pix_en=1 (a "tick").
- draw_r, draw_g, draw_b  in  4 each  colour from the drawing controller for the current scan position.
- curr_x  out  11  current horizontal count, 0..1903.
- curr_y  out  10  current vertical count, 0..933.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-high.
- de  out  1  display-enable, high for visible pixels.
- vga_r, vga_g, vga_b  out  4 each  colour to the DAC pins.
- frame_start  out  1  single-clk pulse at the start of each frame.

Function
REQ-003 SHALL keep curr_x/curr_y as registered counters; on a tick curr_x increments, wrapping 1903->0.
REQ-004 SHALL increment curr_y on the tick where curr_x wraps, wrapping 933->0 on the same tick.
REQ-005 SHALL hold all registers, including outputs, on clk edges with pix_en=0.
REQ-006 SHALL define visible as curr_x<1440 and curr_y<900; hsync-active as 1520<=curr_x<=1671; vsync-active as 903<=curr_y<=908.
REQ-007 SHALL, on each tick, register hsync, vsync and de from the decode of the pre-tick curr_x/curr_y (base latency 1 tick).
REQ-008 SHALL, on each tick, register vga_r/g/b = draw_r/g/b if the pre-tick position was visible, else 4'h0.
REQ-009 SHALL never drive non-zero vga_r/g/b while de=0.
REQ-010 SHALL assert frame_start for exactly one clk after the tick on which curr_x/curr_y go from (1903,933) to (0,0); it SHALL be 0 otherwise, even if pix_en stays low.
REQ-011 SHALL use only unsigned compare logic; counter widths SHALL hold H/V totals without overflow.
REQ-012 SHALL have frame totals: 1904 ticks per line, 934 lines, 1,778,336 ticks per frame.

Reset
REQ-013 SHALL, when rst=1 at a clk edge (regardless of pix_en), set curr_x=0, curr_y=0, hsync=1, vsync=0, de=0, vga_r/g/b=0, frame_start=0, and clear every delay-stage register.
REQ-014 SHALL, when rst is asserted mid-frame, restart at (0,0) on the first tick after release, without emitting frame_start for that restart.
REQ-015 SHALL give rst priority over pix_en and over all counter updates.

Configuration
REQ-016 SHALL support macro SCAN_SYNC_DELAY_EN.
REQ-017 With SCAN_SYNC_DELAY_EN defined: hsync, vsync, de and the visible qualifier SHALL pass through one extra tick stage (latency 2 ticks); vga_r/g/b SHALL sample draw_* one tick later than base, gated by the delayed visible flag, to align with a drawing controller that has one registered stage.
REQ-018 Without SCAN_SYNC_DELAY_EN: latency is exactly REQ-007/REQ-008; no extra stage registers exist.

Verification
REQ-019 Reset then pix_en=1 constant: curr_x counts 0..1903; curr_y increments at wrap; after 1,778,336 ticks (0,0) recurs and frame_start pulses once.
REQ-020 curr_x stepping 1519->1520 on tick N: hsync falls on tick N+1 (N+2 with macro); rises one tick after curr_x=1671->1672; low width 152 ticks.
REQ-021 draw_r/g/b=4'hA/4'h5/4'hF constant: vga_*=A/5/F only while de=1; vga_*=0 during curr_x 1440..1903 and curr_y 900..933.
REQ-022 pix_en toggled 1/0 every clk: counters advance every other clk; hsync width=304 clk; frame_start width=1 clk.
REQ-023 rst=1 for 3 clks at curr_x=700, curr_y=450: outputs at reset values; after release, count resumes from (0,0), no frame_start.
REQ-024 With SCAN_SYNC_DELAY_EN: curr_x step 1439->1440 causes de to fall 2 ticks later; draw_* changed at curr_x=5 appears on vga_* 2 ticks later.
